// File: rtl/soml_pkg.sv
// rtl/soml_pkg.sv - shared constants and state type for the SOML argmin search
package soml_pkg;

    localparam int METRIC_W = 16;

    localparam logic [METRIC_W-1:0] METRIC_ALL_ONES = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } soml_state_e;

endpackage

// File: rtl/soml_cmp_update.sv
// rtl/soml_cmp_update.sv - combinational best/second-best update for one candidate metric
// Optional runner-up tracking: SOML_SECOND_BEST_EN
module soml_cmp_update
    import soml_pkg::*;
#(
    parameter int MW    = 16,
    parameter int IDX_W = 4
) (
    input  logic             first,
    input  logic [MW-1:0]    metric,
    input  logic [IDX_W-1:0] idx,
    input  logic [MW-1:0]    best_metric,
    input  logic [IDX_W-1:0] best_idx,
`ifdef SOML_SECOND_BEST_EN
    input  logic [MW-1:0]    second_metric,
    output logic [MW-1:0]    second_metric_nxt,
`endif
    output logic             update,
    output logic [MW-1:0]    best_metric_nxt,
    output logic [IDX_W-1:0] best_idx_nxt
);

    logic less_best;

    always_comb begin
        less_best       = metric < best_metric;
        // first sample loads unconditionally so an all-ones metric can still win
        update          = first || less_best;
        best_metric_nxt = update ? metric : best_metric;
        best_idx_nxt    = update ? idx : best_idx;
`ifdef SOML_SECOND_BEST_EN
        second_metric_nxt = second_metric;
        if (first) begin
            second_metric_nxt = second_metric;
        end else if (less_best) begin
            second_metric_nxt = best_metric;
        end else if ((metric < second_metric) || (metric == best_metric)) begin
            second_metric_nxt = metric;
        end
`endif
    end

endmodule

// File: rtl/soml_argmin.sv
// rtl/soml_argmin.sv - argmin search over N_CAND accumulated SOML candidate metrics
// Optional runner-up output: SOML_SECOND_BEST_EN
module soml_argmin
    import soml_pkg::*;
#(
    parameter int METRIC_W = 16,
    parameter int N_CAND   = 16,
    parameter int IDX_W    = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                metric_valid,
    input  logic [METRIC_W-1:0] metric,
    output logic                busy,
    output logic                done,
    output logic [IDX_W-1:0]    best_idx,
`ifdef SOML_SECOND_BEST_EN
    output logic [METRIC_W-1:0] second_metric,
`endif
    output logic [METRIC_W-1:0] best_metric
);

    localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(N_CAND - 1);
    localparam logic [METRIC_W-1:0] ONES     = '1;

    soml_state_e          state, state_nxt;
    logic [IDX_W-1:0]     cand_cnt;
    logic                 first;
    logic                 accept;
    logic                 last;
    logic                 upd;
    logic [METRIC_W-1:0]  best_metric_nxt;
    logic [IDX_W-1:0]     best_idx_nxt;
`ifdef SOML_SECOND_BEST_EN
    logic [METRIC_W-1:0]  second_metric_nxt;
`endif

    // start has priority: a valid in the same cycle as start is dropped
    assign accept = (state == ST_SEARCH) && metric_valid && !start;
    assign last   = accept && (cand_cnt == LAST_IDX);
    assign busy   = (state == ST_SEARCH);
    assign done   = (state == ST_DONE);

    soml_cmp_update #(
        .MW    (METRIC_W),
        .IDX_W (IDX_W)
    ) u_cmp (
        .first             (first),
        .metric            (metric),
        .idx               (cand_cnt),
        .best_metric       (best_metric),
        .best_idx          (best_idx),
`ifdef SOML_SECOND_BEST_EN
        .second_metric     (second_metric),
        .second_metric_nxt (second_metric_nxt),
`endif
        .update            (upd),
        .best_metric_nxt   (best_metric_nxt),
        .best_idx_nxt      (best_idx_nxt)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SEARCH;
            ST_SEARCH: begin
                if (start)     state_nxt = ST_SEARCH;
                else if (last) state_nxt = ST_DONE;
            end
            ST_DONE:   state_nxt = start ? ST_SEARCH : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cand_cnt    <= '0;
            first       <= 1'b0;
            best_idx    <= '0;
            best_metric <= ONES;
        end else begin
            state <= state_nxt;
            if (start) begin
                cand_cnt    <= '0;
                first       <= 1'b1;
                best_idx    <= '0;
                best_metric <= ONES;
            end else if (accept) begin
                // hold on the terminal candidate so the counter never wraps
                cand_cnt <= last ? cand_cnt : cand_cnt + 1'b1;
                first    <= 1'b0;
                if (upd) begin
                    best_idx    <= best_idx_nxt;
                    best_metric <= best_metric_nxt;
                end
            end
        end
    end

`ifdef SOML_SECOND_BEST_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            second_metric <= ONES;
        end else if (start) begin
            second_metric <= ONES;
        end else if (accept) begin
            second_metric <= second_metric_nxt;
        end
    end
`endif

endmodule

// File: doc/soml_argmin.md
# soml_argmin

Downstream of the SOML accumulator in the SOML decoder. Each accumulator `finish` pulse delivers one accumulated 16-bit candidate metric. This block takes N_CAND such metrics per search, one per candidate in index order, and tracks the minimum metric and its index. When the last candidate arrives it raises a one-cycle `done` and holds the winning metric and index until the next search starts.

## Interface
Parameters:
- `METRIC_W`, 16, metric width; matches accumulator output.
- `N_CAND`, 16, candidates per search; range 2..256.
- `IDX_W`, 4, index width; must equal clog2(N_CAND).

Ports:
- `clk` input 1: single clock, all logic on posedge.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: one-cycle pulse that begins a new search.
- `metric_valid` input 1: driven by accumulator `finish`; qualifies `metric`.
- `metric` input METRIC_W: candidate metric, unsigned.
- `busy` output 1: high while in SEARCH.
- `done` output 1: one-cycle pulse when the result is final.
- `best_idx` output IDX_W: index of the minimum metric.
- `best_metric` output METRIC_W: the minimum metric value.
- `second_metric` output METRIC_W: second-smallest metric; present only with SOML_SECOND_BEST_EN.

## Operation
- States: IDLE, SEARCH, DONE.
- IDLE:
  - `metric_valid` is ignored.
  - `start` → SEARCH; clear `cand_cnt`; set `first`.
- SEARCH, on each `metric_valid`:
  - If `first`: load `best_metric` = `metric` and `best_idx` = `cand_cnt` unconditionally, so 0xFFFF is a legal winner; clear `first`.
  - Else, if `metric` < `best_metric` (strict, unsigned): update both. Ties keep the earlier index.
  - Increment `cand_cnt` every valid.
  - When the valid being processed has `cand_cnt` == N_CAND-1 → DONE.
- DONE:
  - Lasts exactly one cycle with `done`=1, then → IDLE.
  - `best_*` hold until the next `start` clears them.
- `start` during SEARCH or DONE restarts the search: counters and `first` reset, and any `metric_valid` in that cycle is discarded. Start wins over valid.
- `cand_cnt` never wraps inside a search; the terminal compare ends the search.
- Reset mid-search: everything returns to reset values on the next edge, with no `done` pulse.
- No backpressure. The accumulator issues at most one valid per 9 cycles, and the block accepts one per cycle.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `best_idx`=0, `best_metric`=all ones, `second_metric`=all ones, `cand_cnt`=0.
- `metric` is sampled at the posedge where `metric_valid`=1. `best_*` reflect that sample from the following cycle.
- `done` is high in the cycle after the edge that sampled the last valid. `best_*` are already final in that cycle.
- `busy` rises the cycle after `start` and falls in the DONE cycle.
- A back-to-back `start` in the DONE cycle is accepted: `done` still pulses that cycle, and the next cycle is SEARCH.

## Configuration
- Macro: `SOML_SECOND_BEST_EN`.
- Defined:
  - `second_metric` port exists and holds the runner-up for soft output.
  - A new min shifts the old best into second.
  - Otherwise, `metric` < `second_metric` replaces second.
  - A metric equal to best goes to second.
  - Cleared to all ones on `start`.
- Undefined: the port, register and compare logic are absent; everything else is identical.

## Structure
- Shared package `soml_pkg`:
  - METRIC_W constant.
  - state enum (IDLE/SEARCH/DONE).
  - all-ones metric constant.
- One sub-module `soml_cmp_update`, purely combinational. It takes the current best/second registers, `metric`, `first` and the index. It returns the next best/second values and an update flag. The top level owns the FSM, `cand_cnt` and the registers.

## Test plan
- Reset then `start`, N_CAND=4, metrics 50,30,40,10 → `done` one cycle after the 4th valid; `best_idx`=3; `best_metric`=10; second=30 when enabled.
- Ties: metrics 20,20,25,20 → `best_idx`=0, `best_metric`=20; second=20 when enabled.
- All 0xFFFF → `best_idx`=0, `best_metric`=0xFFFF; the first-load path is exercised.
- `start` after two valids (7,3), then 9,8,6,5 → only the new search counts: `best_idx`=3, `best_metric`=5. `start` coincident with a valid discards that valid.
- `rst_n`=0 for one cycle mid-search → no `done`; outputs at reset values; the next full search is correct.
- Valid spacing of 9 cycles (real accumulator cadence) vs every-cycle valids → identical results; `busy`/`done` timing as specified.
